vga_fb_arbiter: RTL and testbench



---
 rtl/vga_fb_pkg.sv | 14 +
 rtl/vga_fb_arbiter_if.sv | 36 +++
 rtl/vga_fb_arbiter.sv | 99 +++++++++
 tb/tb_vga_fb_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
// rtl/vga_fb_pkg.sv - shared display geometry constants and arbiter FSM state
package vga_fb_pkg;

    localparam int H_ACTIVE       = 640;
    localparam int V_ACTIVE       = 480;
    localparam int WORDS_PER_LINE = 40;
    localparam int FB_WORDS       = WORDS_PER_LINE * V_ACTIVE;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// rtl/vga_fb_arbiter_if.sv - timing, host, framebuffer RAM and line buffer signals of the arbiter
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 15
);

    logic              line_start;
    logic [9:0]        next_line;
    logic              host_valid;
    logic              host_ready;
    logic [ADDR_W-1:0] host_addr;
    logic [15:0]       host_data;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              lb_we;
    logic              lb_bank;
    logic [5:0]        lb_addr;
    logic [15:0]       lb_data;
    logic              fetch_busy;
    logic              underrun;

    modport master (
        output line_start, next_line, host_valid, host_addr, host_data, mem_rdata,
        input  host_ready, mem_en, mem_we, mem_addr, mem_wdata,
        input  lb_we, lb_bank, lb_addr, lb_data, fetch_busy, underrun
    );

    modport slave (
        input  line_start, next_line, host_valid, host_addr, host_data, mem_rdata,
        output host_ready, mem_en, mem_we, mem_addr, mem_wdata,
        output lb_we, lb_bank, lb_addr, lb_data, fetch_busy, underrun
    );

endinterface

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - shares the framebuffer RAM between display line prefetch and host writes
// Display fetch wins the RAM except on every HOST_EVERY-th fetch cycle, which is offered to the host.
module vga_fb_arbiter #(
    parameter int WORDS_PER_LINE = vga_fb_pkg::WORDS_PER_LINE,
    parameter int V_ACTIVE       = vga_fb_pkg::V_ACTIVE,
    parameter int ADDR_W         = 15,
    parameter int FB_WORDS       = vga_fb_pkg::FB_WORDS,
    parameter int HOST_EVERY     = 4
) (
    input logic             clk,
    input logic             rst,
    vga_fb_arbiter_if.slave bus
);

    localparam int SLOT_W = (HOST_EVERY > 1) ? $clog2(HOST_EVERY) : 1;

    vga_fb_pkg::state_t state;
    logic [ADDR_W-1:0]  base;
    logic [5:0]         idx;
    logic [SLOT_W-1:0]  slot;
    logic               bank_q;
    logic               lb_we_q;
    logic [5:0]         lb_addr_q;
    logic               busy_q;
    logic               underrun_q;

    logic fetching;
    logic slot_due;
    logic restart;
    logic host_xfer;
    logic host_wr;
    logic rd_issue;
    logic rd_last;

    assign fetching = (state == vga_fb_pkg::FETCH);
    assign slot_due = (slot == SLOT_W'(HOST_EVERY - 1));
    assign restart  = bus.line_start && (32'(bus.next_line) < 32'(V_ACTIVE));

    // Ready looks only at state, slot counter and host_valid so the host never sees a loop through the RAM path.
    assign bus.host_ready = !rst && (!fetching || (slot_due && bus.host_valid));
    assign host_xfer      = bus.host_ready && bus.host_valid;
    assign host_wr        = host_xfer && (32'(bus.host_addr) < 32'(FB_WORDS));

    // A restart cycle issues no read, so the only trailing strobe belongs to the line being abandoned.
    assign rd_issue = fetching && !(slot_due && bus.host_valid) && !restart;
    assign rd_last  = (idx == 6'(WORDS_PER_LINE - 1));

    assign bus.mem_en    = host_wr || rd_issue;
    assign bus.mem_we    = host_wr;
    assign bus.mem_addr  = host_wr  ? bus.host_addr :
                           rd_issue ? (base + ADDR_W'(idx)) : '0;
    assign bus.mem_wdata = host_wr ? bus.host_data : '0;

    assign bus.lb_we      = lb_we_q;
    assign bus.lb_bank    = bank_q;
    assign bus.lb_addr    = lb_addr_q;
    assign bus.lb_data    = lb_we_q ? bus.mem_rdata : '0;
    assign bus.fetch_busy = busy_q;
    assign bus.underrun   = underrun_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= vga_fb_pkg::IDLE;
            base       <= '0;
            idx        <= '0;
            slot       <= '0;
            bank_q     <= 1'b0;
            lb_we_q    <= 1'b0;
            lb_addr_q  <= '0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= bus.line_start && busy_q;
            lb_we_q    <= rd_issue;
            if (rd_issue) begin
                lb_addr_q <= idx;
            end
            // Busy covers the fetch cycles plus the final read's return strobe.
            busy_q <= restart || fetching;

            if (restart) begin
                state  <= vga_fb_pkg::FETCH;
                base   <= ADDR_W'(bus.next_line) * ADDR_W'(WORDS_PER_LINE);
                idx    <= '0;
                slot   <= '0;
                bank_q <= !bank_q;
            end else if (fetching) begin
                slot <= slot_due ? '0 : slot + SLOT_W'(1);
                if (rd_issue) begin
                    idx <= idx + 6'd1;
                    if (rd_last) begin
                        state <= vga_fb_pkg::IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - directed self-checking bench for vga_fb_arbiter
module tb_vga_fb_arbiter;

    localparam logic [15:0] KEY = 16'h5A3C;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    vga_fb_arbiter_if #(.ADDR_W(15)) bus ();

    vga_fb_arbiter #(.ADDR_W(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // RAM stand-in: read data is the address scrambled with a fixed key, one cycle late.
    always @(posedge clk) begin
        if (bus.mem_en && !bus.mem_we) begin
            bus.mem_rdata <= 16'(bus.mem_addr) ^ KEY;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd(input int a);
        return 32'(16'(a) ^ KEY);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        bit prev_rd;

        rst            = 1'b1;
        bus.line_start = 1'b0;
        bus.next_line  = '0;
        bus.host_valid = 1'b0;
        bus.host_addr  = '0;
        bus.host_data  = '0;
        #2;
        chk("rst_host_ready", 32'(bus.host_ready), 0);
        chk("rst_mem_en",     32'(bus.mem_en), 0);
        chk("rst_lb_we",      32'(bus.lb_we), 0);
        chk("rst_lb_bank",    32'(bus.lb_bank), 0);
        chk("rst_fetch_busy", 32'(bus.fetch_busy), 0);
        chk("rst_underrun",   32'(bus.underrun), 0);

        cyc(); rst = 1'b0; #1;
        chk("idle_host_ready", 32'(bus.host_ready), 1);
        chk("idle_lb_bank",    32'(bus.lb_bank), 0);

        // Line 2, host idle: 40 back-to-back reads from word 80.
        cyc(); bus.line_start = 1'b1; bus.next_line = 10'd2; #1;
        chk("t2_ls_host_ready", 32'(bus.host_ready), 1);
        chk("t2_ls_mem_en",     32'(bus.mem_en), 0);
        chk("t2_ls_busy",       32'(bus.fetch_busy), 0);
        for (int i = 0; i < 40; i++) begin
            cyc(); bus.line_start = 1'b0; #1;
            chk("t2_mem_en",   32'(bus.mem_en), 1);
            chk("t2_mem_we",   32'(bus.mem_we), 0);
            chk("t2_mem_addr", 32'(bus.mem_addr), 80 + i);
            chk("t2_busy",     32'(bus.fetch_busy), 1);
            chk("t2_bank",     32'(bus.lb_bank), 1);
            chk("t2_host_ready", 32'(bus.host_ready), 0);
            if (i == 0) begin
                chk("t2_lb_we_first", 32'(bus.lb_we), 0);
            end else begin
                chk("t2_lb_we",   32'(bus.lb_we), 1);
                chk("t2_lb_addr", 32'(bus.lb_addr), i - 1);
                chk("t2_lb_data", 32'(bus.lb_data), rd(80 + i - 1));
            end
        end
        cyc(); #1;
        chk("t2_tail_lb_we",   32'(bus.lb_we), 1);
        chk("t2_tail_lb_addr", 32'(bus.lb_addr), 39);
        chk("t2_tail_lb_data", 32'(bus.lb_data), rd(119));
        chk("t2_tail_busy",    32'(bus.fetch_busy), 1);
        chk("t2_tail_mem_en",  32'(bus.mem_en), 0);
        cyc(); #1;
        chk("t2_done_busy",  32'(bus.fetch_busy), 0);
        chk("t2_done_lb_we", 32'(bus.lb_we), 0);

        // Line 5 with the host hammering: host owns every 4th fetch cycle.
        cyc();
        bus.line_start = 1'b1; bus.next_line = 10'd5;
        bus.host_valid = 1'b1; bus.host_addr = 15'd7; bus.host_data = 16'hBEEF;
        #1;
        chk("t3_ls_host_ready", 32'(bus.host_ready), 1);
        chk("t3_ls_mem_we",     32'(bus.mem_we), 1);
        chk("t3_ls_mem_addr",   32'(bus.mem_addr), 7);
        k = 0;
        prev_rd = 1'b0;
        for (int c = 1; c <= 53; c++) begin
            cyc(); bus.line_start = 1'b0; #1;
            if (prev_rd) begin
                chk("t3_lb_we",   32'(bus.lb_we), 1);
                chk("t3_lb_addr", 32'(bus.lb_addr), k - 1);
                chk("t3_lb_data", 32'(bus.lb_data), rd(200 + k - 1));
            end else begin
                chk("t3_lb_quiet", 32'(bus.lb_we), 0);
            end
            if (c % 4 == 0) begin
                chk("t3_slot_ready",  32'(bus.host_ready), 1);
                chk("t3_slot_we",     32'(bus.mem_we), 1);
                chk("t3_slot_addr",   32'(bus.mem_addr), 7);
                chk("t3_slot_wdata",  32'(bus.mem_wdata), 32'h0000BEEF);
                prev_rd = 1'b0;
            end else begin
                chk("t3_rd_ready", 32'(bus.host_ready), 0);
                chk("t3_rd_en",    32'(bus.mem_en), 1);
                chk("t3_rd_we",    32'(bus.mem_we), 0);
                chk("t3_rd_addr",  32'(bus.mem_addr), 200 + k);
                k++;
                prev_rd = 1'b1;
            end
        end
        cyc(); #1;
        chk("t3_end_lb_we",      32'(bus.lb_we), 1);
        chk("t3_end_lb_addr",    32'(bus.lb_addr), 39);
        chk("t3_end_busy",       32'(bus.fetch_busy), 1);
        chk("t3_end_host_ready", 32'(bus.host_ready), 1);
        chk("t3_end_bank",       32'(bus.lb_bank), 0);
        cyc(); bus.host_valid = 1'b0; #1;
        chk("t3_done_busy", 32'(bus.fetch_busy), 0);

        // Line 490 lies outside the active area: nothing should move.
        cyc(); bus.line_start = 1'b1; bus.next_line = 10'd490; #1;
        chk("t4_ls_host_ready", 32'(bus.host_ready), 1);
        for (int i = 0; i < 3; i++) begin
            cyc(); bus.line_start = 1'b0; #1;
            chk("t4_mem_en",     32'(bus.mem_en), 0);
            chk("t4_busy",       32'(bus.fetch_busy), 0);
            chk("t4_bank",       32'(bus.lb_bank), 0);
            chk("t4_host_ready", 32'(bus.host_ready), 1);
            chk("t4_underrun",   32'(bus.underrun), 0);
        end

        // Line 10 aborted at fetch cycle 20 by a request for line 11.
        cyc(); bus.line_start = 1'b1; bus.next_line = 10'd10; #1;
        for (int f = 1; f <= 19; f++) begin
            cyc(); bus.line_start = 1'b0; #1;
            chk("t5_mem_addr", 32'(bus.mem_addr), 400 + f - 1);
        end
        cyc(); bus.line_start = 1'b1; bus.next_line = 10'd11; #1;
        chk("t5_abort_mem_en",  32'(bus.mem_en), 0);
        chk("t5_abort_lb_we",   32'(bus.lb_we), 1);
        chk("t5_abort_lb_addr", 32'(bus.lb_addr), 18);
        chk("t5_abort_lb_data", 32'(bus.lb_data), rd(418));
        chk("t5_abort_bank",    32'(bus.lb_bank), 1);
        chk("t5_abort_underrun", 32'(bus.underrun), 0);
        cyc(); bus.line_start = 1'b0; #1;
        chk("t5_underrun",     32'(bus.underrun), 1);
        chk("t5_bank_twice",   32'(bus.lb_bank), 0);
        chk("t5_restart_addr", 32'(bus.mem_addr), 440);
        chk("t5_restart_lb_we", 32'(bus.lb_we), 0);
        chk("t5_restart_busy", 32'(bus.fetch_busy), 1);
        for (int j = 1; j < 40; j++) begin
            cyc(); #1;
            if (j == 1) begin
                chk("t5_underrun_once", 32'(bus.underrun), 0);
            end
            chk("t5_re_mem_addr", 32'(bus.mem_addr), 440 + j);
            chk("t5_re_lb_we",    32'(bus.lb_we), 1);
            chk("t5_re_lb_addr",  32'(bus.lb_addr), j - 1);
            chk("t5_re_lb_data",  32'(bus.lb_data), rd(440 + j - 1));
        end
        cyc(); #1;
        chk("t5_tail_lb_addr", 32'(bus.lb_addr), 39);
        chk("t5_tail_mem_en",  32'(bus.mem_en), 0);
        cyc(); #1;
        chk("t5_done_busy", 32'(bus.fetch_busy), 0);

        // Reset landing in the middle of a fetch of line 3.
        cyc(); bus.line_start = 1'b1; bus.next_line = 10'd3; #1;
        for (int f = 1; f <= 9; f++) begin
            cyc(); bus.line_start = 1'b0; #1;
        end
        cyc(); #1;
        chk("t6_pre_bank", 32'(bus.lb_bank), 1);
        rst = 1'b1; #1;
        chk("t6_rst_mem_en",     32'(bus.mem_en), 0);
        chk("t6_rst_mem_addr",   32'(bus.mem_addr), 0);
        chk("t6_rst_lb_we",      32'(bus.lb_we), 0);
        chk("t6_rst_lb_addr",    32'(bus.lb_addr), 0);
        chk("t6_rst_bank",       32'(bus.lb_bank), 0);
        chk("t6_rst_busy",       32'(bus.fetch_busy), 0);
        chk("t6_rst_host_ready", 32'(bus.host_ready), 0);
        cyc(); rst = 1'b0; #1;
        chk("t6_rel_host_ready", 32'(bus.host_ready), 1);
        chk("t6_rel_busy",       32'(bus.fetch_busy), 0);
        chk("t6_rel_mem_en",     32'(bus.mem_en), 0);
        cyc(); #1;
        chk("t6_idle_mem_en", 32'(bus.mem_en), 0);
        chk("t6_idle_bank",   32'(bus.lb_bank), 0);

        // Host address range boundary while idle.
        cyc(); bus.host_valid = 1'b1; bus.host_addr = 15'd19200; bus.host_data = 16'h1234; #1;
        chk("t7_oob_ready",  32'(bus.host_ready), 1);
        chk("t7_oob_mem_en", 32'(bus.mem_en), 0);
        cyc(); bus.host_addr = 15'd19199; #1;
        chk("t7_last_mem_en", 32'(bus.mem_en), 1);
        chk("t7_last_mem_we", 32'(bus.mem_we), 1);
        chk("t7_last_addr",   32'(bus.mem_addr), 19199);
        chk("t7_last_wdata",  32'(bus.mem_wdata), 32'h00001234);
        cyc(); bus.host_valid = 1'b0; #1;
        chk("t7_after_mem_en", 32'(bus.mem_en), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
